// File: rtl/sd_sector_loader.sv
// Multi-sector SD read sequencer. It issues one read per sector and streams each
// 512-byte payload into byte-wide memory, with a per-sector timeout and retry.
module sd_sector_loader #(
    parameter int MEM_AW         = 17,
    parameter int BYTE_ADDRESSED = 1,
    parameter int TIMEOUT        = 2000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       start_sector,
    input  logic [15:0]       sector_count,
    input  logic [MEM_AW-1:0] mem_base,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic              sd_idle,
    input  logic              sd_byte_valid,
    input  logic [7:0]        sd_byte,
    output logic              sd_begin_read,
    output logic [31:0]       sd_addr,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [9:0] LAST_BYTE = 10'd511;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_DATA, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t            state;
    logic [31:0]       sector;
    logic [15:0]       remaining;
    logic [MEM_AW-1:0] base;
    logic [RW-1:0]     retry_left;
    logic [9:0]        byte_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              card_busy_seen;

    logic [31:0] sd_addr_next;
    logic        tmo_hit;
    logic        last_byte;
    logic        attempt_fail;

    assign sd_addr_next = (BYTE_ADDRESSED != 0) ? {sector[22:0], 9'b0} : sector;
    assign tmo_hit      = (tmo_cnt == TW'(TIMEOUT - 1));
    assign last_byte    = sd_byte_valid && (byte_cnt == LAST_BYTE);

    // sd_idle is only a short-sector indication once the card has gone busy
    // for this attempt; right after the request it may still read idle.
    always_comb begin
        attempt_fail = 1'b0;
        case (state)
            S_ISSUE: attempt_fail = !sd_idle && tmo_hit;
            S_DATA:  attempt_fail = !last_byte &&
                                    (tmo_hit || (card_busy_seen && sd_idle && !sd_byte_valid));
            default: attempt_fail = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            sd_begin_read  <= 1'b0;
            sd_addr        <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            sector         <= '0;
            remaining      <= '0;
            base           <= '0;
            retry_left     <= '0;
            byte_cnt       <= '0;
            tmo_cnt        <= '0;
            card_busy_seen <= 1'b0;
        end else begin
            // NOTE: pulses default low with non-blocking assignments; a later
            // assignment in this block wins, so each branch only raises what it needs.
            done          <= 1'b0;
            sd_begin_read <= 1'b0;
            mem_we        <= 1'b0;

            case (state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        sector     <= start_sector;
                        remaining  <= sector_count;
                        base       <= mem_base;
                        retry_left <= RW'(MAX_RETRY);
                        tmo_cnt    <= '0;
                        error      <= 1'b0;
                        if (sector_count == 16'd0) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (sd_idle) begin
                        sd_begin_read  <= 1'b1;
                        sd_addr        <= sd_addr_next;
                        byte_cnt       <= '0;
                        tmo_cnt        <= '0;
                        mem_addr       <= base;
                        card_busy_seen <= 1'b0;
                        state          <= S_DATA;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_DATA: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (!sd_idle) card_busy_seen <= 1'b1;
                    if (sd_byte_valid) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= sd_byte;
                        mem_addr  <= base + MEM_AW'(byte_cnt);
                        byte_cnt  <= byte_cnt + 10'd1;
                        if (last_byte) state <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (sd_idle) begin
                        sector    <= sector + 32'd1;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= S_DONE;
                        end else begin
                            base       <= base + MEM_AW'(512);
                            retry_left <= RW'(MAX_RETRY);
                            tmo_cnt    <= '0;
                            state      <= S_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase

            // A failed attempt rewrites the same sector from its base.
            if (attempt_fail) begin
                tmo_cnt <= '0;
                if (retry_left != '0) begin
                    retry_left <= retry_left - RW'(1);
                    state      <= S_ISSUE;
                end else begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_ERROR;
                end
            end
        end
    end
endmodule

// File: tb/tb_sd_sector_loader.sv
// Scoreboard bench for sd_sector_loader: a card model issues bytes and queues the
// expected reads/writes/done pulses; a negedge monitor pops and compares them.
module tb_sd_sector_loader;
    localparam int AW = 17;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   start_sector = '0;
    logic [15:0]   sector_count = '0;
    logic [AW-1:0] mem_base = '0;
    logic          busy, done, error;
    logic          sd_idle = 1'b1;
    logic          sd_byte_valid = 1'b0;
    logic [7:0]    sd_byte = '0;
    logic          sd_begin_read;
    logic [31:0]   sd_addr;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    int          exp_done = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        prev_idle = 1'b1;
    logic [31:0] cur_sd = '0;

    always #5 clock = ~clock;

    sd_sector_loader #(
        .MEM_AW(AW), .BYTE_ADDRESSED(1), .TIMEOUT(1000), .MAX_RETRY(3)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .start_sector(start_sector),
        .sector_count(sector_count), .mem_base(mem_base), .busy(busy), .done(done),
        .error(error), .sd_idle(sd_idle), .sd_byte_valid(sd_byte_valid),
        .sd_byte(sd_byte), .sd_begin_read(sd_begin_read), .sd_addr(sd_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT event must match the head of its expectation queue.
    always @(negedge clock) begin
        wr_t w;
        if (sd_begin_read) begin
            check("rd_expected", exp_rd.size() != 0, 1);
            if (exp_rd.size() != 0) begin
                cur_sd = exp_rd.pop_front();
                check("sd_addr", sd_addr, cur_sd);
                check("issue_after_idle", prev_idle, 1);
            end
        end
        if (mem_we) begin
            check("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                check("mem_addr", mem_addr, w.addr);
                check("mem_wdata", mem_wdata, w.data);
                check("sd_addr_hold", sd_addr, cur_sd);
            end
        end
        if (done) begin
            check("done_expected", exp_done > 0, 1);
            if (exp_done > 0) exp_done--;
            check("busy_at_done", busy, 0);
        end
        prev_idle = sd_idle;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [15:0] c, input logic [AW-1:0] b);
        start_sector = s;
        sector_count = c;
        mem_base     = b;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Card model: waits for a request, then sends nbytes (seed + index); tail < 0
    // leaves the card busy, otherwise it returns idle after tail cycles.
    task automatic serve(input int nbytes, input logic [31:0] exp_sd, input logic [AW-1:0] wbase,
                         input logic [7:0] seed, input int poke_at, input int tail);
        int n = 0;
        exp_rd.push_back(exp_sd);
        while (!sd_begin_read && n < 3000) begin
            tick();
            n++;
        end
        check("begin_read_wait", n < 3000, 1);
        if (nbytes > 0) sd_idle = 1'b0;
        tick();
        if (nbytes == 0) return;
        tick();
        for (int i = 0; i < nbytes; i++) begin
            if (i % 128 == 127) begin
                sd_byte_valid = 1'b0;
                tick();
            end
            sd_byte_valid = 1'b1;
            sd_byte       = 8'(i) + seed;
            start         = (i == poke_at);
            exp_wr.push_back('{wbase + AW'(i), sd_byte});
            tick();
        end
        sd_byte_valid = 1'b0;
        start         = 1'b0;
        if (tail >= 0) begin
            repeat (tail) tick();
            sd_idle = 1'b1;
        end
    endtask

    task automatic wait_not_busy(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check(name, busy, 0);
        tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_begin_read", sd_begin_read, 0);
        check("rst_sd_addr", sd_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        tick();

        // Single sector, byte addressing: 5 << 9 = 0xA00.
        exp_done++;
        do_start(32'd5, 16'd1, 17'h00100);
        check("t1_busy", busy, 1);
        serve(512, 32'h0000_0A00, 17'h00100, 8'h00, -1, 2);
        wait_not_busy("t1_busy_low");
        check("t1_done_count", exp_done, 0);
        check("t1_error", error, 0);

        // Three sectors with a start poked mid-sector that must be ignored.
        exp_done++;
        do_start(32'h10, 16'd3, 17'h00400);
        serve(512, 32'h0000_2000, 17'h00400, 8'h11, -1, 3);
        start_sector = 32'hDEAD_BEEF;
        sector_count = 16'd7;
        mem_base     = 17'h01234;
        serve(512, 32'h0000_2200, 17'h00600, 8'h22, 50, 3);
        serve(512, 32'h0000_2400, 17'h00800, 8'h33, -1, 3);
        wait_not_busy("t2_busy_low");
        check("t2_done_count", exp_done, 0);

        // Short first attempt, then a clean retry of the same sector.
        exp_done++;
        do_start(32'h21, 16'd1, 17'h03000);
        serve(100, 32'h0000_4200, 17'h03000, 8'h55, -1, 0);
        serve(512, 32'h0000_4200, 17'h03000, 8'h00, -1, 2);
        wait_not_busy("t3_busy_low");
        check("t3_done_count", exp_done, 0);
        check("t3_error", error, 0);

        // Zero-count start: done on the next cycle, no read.
        exp_done++;
        do_start(32'h77, 16'd0, 17'h00055);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        tick();
        check("t4_done_pulse", done, 0);
        check("t4_done_count", exp_done, 0);

        // Card never sends data: 1 + 3 requests, then sticky error.
        do_start(32'h30, 16'd1, 17'h04000);
        repeat (4) serve(0, 32'h0000_6000, 17'h04000, 8'h00, -1, 0);
        n = 0;
        while (!error && n < 3000) begin
            tick();
            n++;
        end
        check("t5_error", error, 1);
        check("t5_busy", busy, 0);
        repeat (20) tick();
        check("t5_error_sticky", error, 1);
        check("t5_no_done", exp_done, 0);
        exp_done++;
        do_start(32'h0, 16'd0, 17'h0);
        check("t5_error_cleared", error, 0);
        check("t5_restart_done", done, 1);
        tick();

        // Reset after 200 bytes of the second sector.
        do_start(32'h40, 16'd3, 17'h08000);
        serve(512, 32'h0000_8000, 17'h08000, 8'h44, -1, 2);
        serve(200, 32'h0000_8200, 17'h08200, 8'h66, -1, -1);
        reset = 1'b1;
        tick();
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_error", error, 0);
        check("t6_begin_read", sd_begin_read, 0);
        check("t6_sd_addr", sd_addr, 0);
        check("t6_mem_we", mem_we, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_mem_wdata", mem_wdata, 0);
        check("t6_writes_drained", exp_wr.size(), 0);
        sd_idle = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();

        // After reset: sector bit 23 truncated in sd_addr, mem_addr wraps at 2^17.
        exp_done++;
        do_start(32'h0080_0003, 16'd1, 17'h1FF00);
        serve(512, 32'h0000_0600, 17'h1FF00, 8'h3C, -1, 2);
        wait_not_busy("t7_busy_low");
        check("t7_done_count", exp_done, 0);

        repeat (5) tick();
        check("end_rd_queue", exp_rd.size(), 0);
        check("end_wr_queue", exp_wr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
